// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared keyboard command codes, status bits and sequencer types
package kbd_pkg;

    localparam logic [7:0] KBD_CMD_RESET   = 8'hFF;
    localparam logic [7:0] KBD_CMD_SET_LED = 8'hED;
    localparam logic [7:0] KBD_RSP_ACK     = 8'hFA;
    localparam logic [7:0] KBD_RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] KBD_RSP_RESEND  = 8'hFE;
    localparam logic [7:0] KBD_RSP_ERROR   = 8'hFC;

    localparam int STAT_RX_READY     = 3;
    localparam int STAT_TX_READY     = 2;
    localparam int STAT_RX_OVERWRITE = 1;

    typedef enum logic [2:0] {
        IDLE, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, TX_WR, DONE, ERR
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE, CMD_INIT, CMD_LED
    } cmd_e;

endpackage

// File: rtl/kbd_timeout.sv
// rtl/kbd_timeout.sv - saturating response timer, expire holds until the next load
module kbd_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i && cnt_q != LIMIT_V) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/kbd_cmd_sequencer.sv
// rtl/kbd_cmd_sequencer.sv - polls the keyboard port, runs INIT/LED commands with retry, forwards scan codes
module kbd_cmd_sequencer
    import kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       kb_a,
    output logic       kb_ce,
    output logic       kb_wren,
    output logic       kb_ren,
    output logic [7:0] kb_wdata,
    input  logic [7:0] kb_rdata,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       rx_lost
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic               step_q, step_d;
    logic               tx_pend_q, tx_pend_d;
    logic               await_q, await_d;
    logic               wait_q, wait_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [2:0]         mask_q, mask_d;
    logic               scan_valid_q, scan_valid_d;
    logic [7:0]         scan_code_q, scan_code_d;
    logic               rx_lost_q, rx_lost_d;
    logic               tmr_load, tmr_expire, resend;
    logic [7:0]         tx_byte, rsp_exp;

    kbd_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .en_i     (await_q),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= CMD_NONE;
            step_q       <= 1'b0;
            tx_pend_q    <= 1'b0;
            await_q      <= 1'b0;
            wait_q       <= 1'b0;
            retry_q      <= '0;
            mask_q       <= 3'b000;
            scan_valid_q <= 1'b0;
            scan_code_q  <= 8'h00;
            rx_lost_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            step_q       <= step_d;
            tx_pend_q    <= tx_pend_d;
            await_q      <= await_d;
            wait_q       <= wait_d;
            retry_q      <= retry_d;
            mask_q       <= mask_d;
            scan_valid_q <= scan_valid_d;
            scan_code_q  <= scan_code_d;
            rx_lost_q    <= rx_lost_d;
        end
    end

    always_comb begin
        tx_byte = KBD_CMD_RESET;
        if (cmd_q == CMD_LED) begin
            tx_byte = step_q ? {5'b00000, mask_q} : KBD_CMD_SET_LED;
        end
        rsp_exp = (cmd_q == CMD_INIT && step_q) ? KBD_RSP_BAT_OK : KBD_RSP_ACK;
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        step_d       = step_q;
        tx_pend_d    = tx_pend_q;
        await_d      = await_q;
        wait_d       = wait_q;
        retry_d      = retry_q;
        mask_d       = mask_q;
        scan_valid_d = 1'b0;
        scan_code_d  = scan_code_q;
        rx_lost_d    = 1'b0;
        tmr_load     = 1'b0;
        resend       = 1'b0;

        // New commands are latched whenever none is active; the poll loop picks them up.
        if (cmd_q == CMD_NONE) begin
            if (init_req) begin
                cmd_d     = CMD_INIT;
                step_d    = 1'b0;
                tx_pend_d = 1'b1;
                await_d   = 1'b0;
                retry_d   = '0;
            end else if (led_req) begin
                cmd_d     = CMD_LED;
                mask_d    = led_mask;
                step_d    = 1'b0;
                tx_pend_d = 1'b1;
                await_d   = 1'b0;
                retry_d   = '0;
            end
        end

        case (state_q)
            IDLE: begin
                state_d = STAT_RD;
                if (await_q && tmr_expire) begin
                    resend = 1'b1;
                end
            end
            STAT_RD: begin
                state_d = STAT_WAIT;
                wait_d  = 1'b0;
            end
            STAT_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    rx_lost_d = kb_rdata[STAT_RX_OVERWRITE];
                    if (kb_rdata[STAT_RX_READY]) begin
                        state_d = DATA_RD;
                    end else if (tx_pend_q && kb_rdata[STAT_TX_READY]) begin
                        state_d = TX_WR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA_RD: begin
                state_d = DATA_WAIT;
                wait_d  = 1'b0;
            end
            DATA_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (await_q && kb_rdata == rsp_exp) begin
                        tmr_load = 1'b1;
                        if (!step_q) begin
                            step_d = 1'b1;
                            if (cmd_q == CMD_LED) begin
                                tx_pend_d = 1'b1;
                                await_d   = 1'b0;
                                retry_d   = '0;
                            end
                        end else begin
                            state_d = DONE;
                            await_d = 1'b0;
                        end
                    end else if (await_q && kb_rdata == KBD_RSP_RESEND) begin
                        tmr_load = 1'b1;
                        resend   = 1'b1;
                    end else if (await_q && kb_rdata == KBD_RSP_ERROR) begin
                        state_d = ERR;
                        await_d = 1'b0;
                    end else begin
                        if (await_q) begin
                            tmr_load = 1'b1;
                        end
                        scan_valid_d = 1'b1;
                        scan_code_d  = kb_rdata;
                    end
                end
            end
            TX_WR: begin
                state_d   = IDLE;
                tx_pend_d = 1'b0;
                await_d   = 1'b1;
                tmr_load  = 1'b1;
                retry_d   = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
            end
            DONE, ERR: begin
                state_d   = IDLE;
                cmd_d     = CMD_NONE;
                tx_pend_d = 1'b0;
                await_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A resend after an INIT 0xFA restarts from the 0xFF byte, so the 0xFA is expected again.
        if (resend) begin
            await_d = 1'b0;
            if (retry_q >= RETRY_MAX) begin
                state_d = ERR;
            end else begin
                tx_pend_d = 1'b1;
                if (cmd_q == CMD_INIT) begin
                    step_d = 1'b0;
                end
            end
        end
    end

    assign kb_a       = (state_q == STAT_RD);
    assign kb_ren     = (state_q == STAT_RD) || (state_q == DATA_RD);
    assign kb_wren    = (state_q == TX_WR);
    assign kb_ce      = kb_ren || kb_wren;
    assign kb_wdata   = (state_q == TX_WR) ? tx_byte : 8'h00;
    assign busy       = (cmd_q != CMD_NONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign rx_lost    = rx_lost_q;

endmodule

// File: doc/kbd_cmd_sequencer.md
KBD_CMD_SEQUENCER -- requirements
Module: kbd_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 1000000, meaning clk cycles to wait for each expected keyboard response byte.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, meaning transmissions allowed per command byte, counting the first.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports kb_a, kb_ce, kb_wren and kb_ren, outputs, 1 bit each, keyboard register select and strobes; kb_a=1 selects status, kb_a=0 selects data.
REQ-006 The block SHALL have ports kb_wdata (output, 8, byte to keyboard TX queue) and kb_rdata (input, 8, keyboard read data valid 2 cycles after a read strobe).
REQ-007 The block SHALL have ports init_req and led_req (inputs, 1 each, single-cycle command requests) and led_mask (input, 3, {caps,num,scroll} sampled on led_req).
REQ-008 The block SHALL have ports busy (output, 1, command in progress), done (output, 1, one-cycle success pulse) and error (output, 1, one-cycle failure pulse).
REQ-009 The block SHALL have ports scan_valid (output, 1, one-cycle pulse), scan_code (output, 8, forwarded byte) and rx_lost (output, 1, one-cycle pulse when keyboard reports RX overwrite).

Function
REQ-010 At most one kb strobe SHALL be asserted per cycle, each for exactly one cycle, and no new access SHALL start until 2 cycles after the previous read strobe.
REQ-011 Poll loop: the block SHALL issue a status read (kb_a=1, kb_ce=1, kb_ren=1), wait 2 cycles, then sample kb_rdata; bit3 is RX ready, bit2 is TX ready, bit1 is RX overwrite.
REQ-012 If status bit1=1, rx_lost SHALL pulse for one cycle.
REQ-013 If status bit3=1, the block SHALL issue a data read (kb_a=0), sample the byte 2 cycles later, and return to polling.
REQ-014 States SHALL be: IDLE, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, TX_WR, DONE, ERR.
REQ-015 In IDLE, init_req SHALL start an INIT command and led_req SHALL start an LED command; if both are asserted in the same cycle, INIT wins and led_req is dropped.
REQ-016 busy SHALL be 1 from the cycle after an accepted request until the done or error pulse, inclusive; requests arriving while busy=1 SHALL be ignored.
REQ-017 INIT sequence: transmit 0xFF, expect 0xFA, then expect 0xAA; on 0xAA, pulse done.
REQ-018 LED sequence: transmit 0xED, expect 0xFA, transmit {5'b0,led_mask}, expect 0xFA, then pulse done.
REQ-019 A byte SHALL be transmitted only after a status read shows bit2=1, via one cycle of kb_a=0, kb_ce=1, kb_wren=1 with kb_wdata holding the byte.
REQ-020 Received 0xFE while awaiting a response SHALL retransmit the current command byte and increment the retry count.
REQ-021 Received 0xFC, or 0xFE once the retry count equals MAX_RETRY, SHALL end the command with an error pulse.
REQ-022 The response timer SHALL reset on each transmit and each received byte; expiry at ACK_TIMEOUT SHALL be handled as 0xFE.
REQ-023 Received bytes that are not an expected response, 0xFE or 0xFC (including every byte when no command is active) SHALL be forwarded: scan_code=byte and scan_valid pulses 1 cycle, in the cycle after the sample.
REQ-024 Retry and timer counters SHALL saturate and never wrap.

Reset
REQ-025 Reset SHALL force state IDLE, all kb strobes 0, kb_a=0, kb_wdata=0x00, scan_code=0x00, busy/done/error/scan_valid/rx_lost=0, and clear the counters.
REQ-026 Reset mid-command SHALL abort the command with no done or error pulse.

Structure
REQ-027 Command and response codes (0xFF, 0xED, 0xFA, 0xAA, 0xFE, 0xFC) and status bit indices SHALL be defined as constants in a shared package kbd_pkg.
REQ-028 The response timer SHALL be a sub-module kbd_timeout (load, expire); the FSM SHALL stay in the top level.

Verification
REQ-029 With an idle bus model and status=0x08, data=0x1C: scan_valid pulses once with scan_code=0x1C.
REQ-030 init_req with the model returning 0xFA then 0xAA: writes 0xFF once, done pulses, busy falls.
REQ-031 led_req with led_mask=3'b101: writes 0xED then 0x05, two 0xFA responses, done pulses.
REQ-032 INIT with the model returning 0xFE three times: 0xFF is written 3 times, then error pulses and no done.
REQ-033 No response with ACK_TIMEOUT=100: 0xFF is rewritten every ~100 cycles, error after the 3rd timeout.
REQ-034 Status=0x0A: rx_lost pulses; init_req and led_req in the same cycle run INIT only; reset asserted mid-LED command returns all outputs to reset values.
